// File: rtl/ysyx_220053_pkg.sv
// Shared constants, fetch state encoding and word-select helper for the
// ysyx_220053 instruction fetch slice.
package ysyx_220053_pkg;

  localparam logic [63:0] RESET_PC  = 64'h8000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    MISA = 3'd4
  } fetch_state_e;

  // Memory returns a doubleword; pc[2] picks which 32-bit half holds the instruction.
  function automatic logic [31:0] word_sel(input logic [63:0] data, input logic hi);
    return hi ? data[63:32] : data[31:0];
  endfunction

endpackage

// File: rtl/ysyx_220053_pc_reg.sv
// Architectural PC register: async active-low reset to RESET_VAL, loads
// load_val when load_en is high, otherwise holds.
module ysyx_220053_pc_reg #(
  parameter logic [63:0] RESET_VAL = ysyx_220053_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic [63:0] load_val,
  output logic [63:0] pc
);

  logic [63:0] pc_q;
  logic [63:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = load_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VAL;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/ysyx_220053_ifu.sv
// Instruction fetch unit: one outstanding doubleword read per instruction,
// word select by pc[2], and a valid/ready hand-off of {instr, pc} to decode.
module ysyx_220053_ifu #(
  parameter logic [63:0] RESET_PC  = ysyx_220053_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = ysyx_220053_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [63:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] instr_o,
  output logic [63:0] pc_o,
  output logic        fetch_err,
  input  logic [63:0] dnpc
);

  import ysyx_220053_pkg::*;

  fetch_state_e state_q;
  fetch_state_e state_d;

  logic [31:0] instr_q;
  logic [31:0] instr_d;
  logic        fetch_err_q;
  logic        fetch_err_d;

  logic [63:0] pc;
  logic        id_fire;
  logic        dnpc_misaligned;

  assign id_fire         = (state_q == HOLD) && id_ready;
  assign dnpc_misaligned = (dnpc[1:0] != 2'b00);

  ysyx_220053_pc_reg #(
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (id_fire),
    .load_val (dnpc),
    .pc       (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (id_ready) begin
          state_d = dnpc_misaligned ? MISA : REQ;
        end
      end
      MISA:    state_d = HOLD;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    imem_req_valid = (state_q == REQ);
    id_valid       = (state_q == HOLD);
  end

  // Responses outside WAIT are ignored; a fault on the response always wins over its data.
  always_comb begin
    instr_d     = instr_q;
    fetch_err_d = fetch_err_q;
    if ((state_q == WAIT) && imem_rsp_valid) begin
      if (imem_rsp_err) begin
        instr_d     = NOP_INSTR;
        fetch_err_d = 1'b1;
      end else begin
        instr_d     = word_sel(imem_rsp_data, pc[2]);
        fetch_err_d = 1'b0;
      end
    end else if (state_q == MISA) begin
      instr_d     = NOP_INSTR;
      fetch_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q     <= NOP_INSTR;
      fetch_err_q <= 1'b0;
    end else begin
      instr_q     <= instr_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign imem_addr = {pc[63:3], 3'b000};
  assign instr_o   = instr_q;
  assign pc_o      = pc;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// Self-checking bench for ysyx_220053_ifu: directed scenarios plus a randomized
// run against an instruction-stream reference model.
module tb_ysyx_220053_ifu;

  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [63:0] imem_rsp_data = 64'h0;
  logic        imem_rsp_err = 1'b0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] instr_o;
  logic [63:0] pc_o;
  logic        fetch_err;
  logic [63:0] dnpc = 64'h0;

  int checks = 0;
  int errors = 0;

  // memory model state
  bit          pend = 0;
  int unsigned lat_cnt = 0;
  logic [63:0] pend_addr = 64'h0;
  int unsigned max_lat = 0;
  bit          force_err = 0;
  bit          fault_en = 0;
  bit          req_acc;
  logic [63:0] acc_addr;

  always #5 clk = ~clk;

  ysyx_220053_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .instr_o        (instr_o),
    .pc_o           (pc_o),
    .fetch_err      (fetch_err),
    .dnpc           (dnpc)
  );

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == RST_PC) return 64'h00100093_00000013;
    return {a[31:0] ^ 32'hC0DE_F00D, a[31:0] + 32'h0000_1357};
  endfunction

  function automatic bit mem_fault(input logic [63:0] a);
    return fault_en && (a[6:3] == 4'hB);
  endfunction

  // One clock: record the request handshake, advance, then drive the memory response.
  task automatic tick();
    req_acc  = imem_req_valid && imem_req_ready;
    acc_addr = imem_addr;
    @(posedge clk);
    @(negedge clk);
    if (req_acc) begin
      pend      = 1;
      pend_addr = acc_addr;
      lat_cnt   = $urandom_range(max_lat, 0);
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    imem_rsp_data  = {$urandom, $urandom};
    if (pend) begin
      if (lat_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        imem_rsp_err   = mem_fault(pend_addr) || force_err;
        force_err      = 0;
        pend           = 0;
      end else begin
        lat_cnt--;
      end
    end
  endtask

  task automatic wait_hold(output bit ok);
    ok = 0;
    for (int i = 0; i < 32; i++) begin
      if (id_valid) begin
        ok = 1;
        return;
      end
      tick();
    end
  endtask

  task automatic handshake(input logic [63:0] next_pc);
    dnpc     = next_pc;
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    id_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids: id_valid=%b req_valid=%b required 0 0", id_valid, imem_req_valid);
    end
    checks++;
    if (instr_o !== NOP || pc_o !== RST_PC || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: instr=%h pc=%h err=%b required %h %h 0", instr_o, pc_o, fetch_err, NOP, RST_PC);
    end
    imem_req_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || id_valid !== 1'b0 || imem_addr !== RST_PC) begin
      errors++;
      $display("FAIL boot_req: req_valid=%b id_valid=%b addr=%h required 1 0 %h", imem_req_valid, id_valid, imem_addr, RST_PC);
    end
    tick();
    checks++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL boot_wait: req_valid=%b id_valid=%b required 0 0", imem_req_valid, id_valid);
    end
    tick();
    checks++;
    if (id_valid !== 1'b1 || instr_o !== 32'h0000_0013 || pc_o !== RST_PC || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL first_fetch: id_valid=%b instr=%h pc=%h err=%b required 1 00000013 %h 0", id_valid, instr_o, pc_o, fetch_err, RST_PC);
    end
  endtask

  task automatic test_upper_word();
    bit ok;
    handshake(64'h8000_0004);
    checks++;
    if (pc_o !== 64'h8000_0004 || imem_req_valid !== 1'b1 || imem_addr !== RST_PC || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL upper_req: pc=%h req_valid=%b addr=%h id_valid=%b required 80000004 1 %h 0", pc_o, imem_req_valid, imem_addr, id_valid, RST_PC);
    end
    wait_hold(ok);
    checks++;
    if (!ok || instr_o !== 32'h0010_0093 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL upper_word: ok=%b instr=%h err=%b required 1 00100093 0", ok, instr_o, fetch_err);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (id_valid !== 1'b1 || imem_req_valid !== 1'b0 || instr_o !== 32'h0010_0093 || pc_o !== 64'h8000_0004) begin
        errors++;
        $display("FAIL stall_%0d: id_valid=%b req_valid=%b instr=%h pc=%h required 1 0 00100093 80000004", i, id_valid, imem_req_valid, instr_o, pc_o);
      end
    end
  endtask

  task automatic test_fault();
    bit ok;
    logic [63:0] w;
    force_err = 1;
    handshake(64'h8000_0008);
    wait_hold(ok);
    checks++;
    if (!ok || instr_o !== NOP || fetch_err !== 1'b1 || pc_o !== 64'h8000_0008) begin
      errors++;
      $display("FAIL fault_nop: ok=%b instr=%h err=%b pc=%h required 1 %h 1 80000008", ok, instr_o, fetch_err, pc_o, NOP);
    end
    handshake(64'h8000_000C);
    wait_hold(ok);
    w = mem_word(64'h8000_0008);
    checks++;
    if (!ok || instr_o !== w[63:32] || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear: ok=%b instr=%h err=%b required 1 %h 0", ok, instr_o, fetch_err, w[63:32]);
    end
  endtask

  task automatic test_misaligned();
    bit ok;
    logic [63:0] w;
    handshake(64'h8000_0006);
    checks++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL misa_noreq: req_valid=%b id_valid=%b required 0 0", imem_req_valid, id_valid);
    end
    tick();
    checks++;
    if (id_valid !== 1'b1 || imem_req_valid !== 1'b0 || fetch_err !== 1'b1 || pc_o !== 64'h8000_0006 || instr_o !== NOP) begin
      errors++;
      $display("FAIL misa_hold: id_valid=%b req_valid=%b err=%b pc=%h instr=%h required 1 0 1 80000006 %h", id_valid, imem_req_valid, fetch_err, pc_o, instr_o, NOP);
    end
    handshake(64'h8000_0010);
    wait_hold(ok);
    w = mem_word(64'h8000_0010);
    checks++;
    if (!ok || instr_o !== w[31:0] || fetch_err !== 1'b0 || pc_o !== 64'h8000_0010) begin
      errors++;
      $display("FAIL misa_recover: ok=%b instr=%h err=%b pc=%h required 1 %h 0 80000010", ok, instr_o, fetch_err, pc_o, w[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    handshake(64'h8000_0020);
    tick();
    checks++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || imem_rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_wait: req_valid=%b id_valid=%b rsp_valid=%b required 0 0 1", imem_req_valid, id_valid, imem_rsp_valid);
    end
    rst_n = 1'b0;
    pend = 0;
    imem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (id_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc_o !== RST_PC || instr_o !== NOP || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: id_valid=%b req_valid=%b pc=%h instr=%h err=%b required 0 0 %h %h 0", id_valid, imem_req_valid, pc_o, instr_o, fetch_err, RST_PC, NOP);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin
      errors++;
      $display("FAIL mid_refetch: req_valid=%b addr=%h required 1 %h", imem_req_valid, imem_addr, RST_PC);
    end
    wait_hold(ok);
    checks++;
    if (!ok || instr_o !== 32'h0000_0013 || pc_o !== RST_PC) begin
      errors++;
      $display("FAIL mid_refetch_data: ok=%b instr=%h pc=%h required 1 00000013 %h", ok, instr_o, pc_o, RST_PC);
    end
  endtask

  // Reference: every delivered instruction is the word at the architectural PC,
  // or a NOP with fetch_err when the PC is misaligned or the fetch faulted.
  task automatic test_random();
    logic [63:0] model_pc;
    bit          model_misa;
    int          n_hs;
    int unsigned r;
    logic [63:0] w;
    logic [31:0] exp_instr;
    bit          exp_err;
    model_pc   = RST_PC;
    model_misa = 0;
    n_hs       = 0;
    fault_en   = 1;
    max_lat    = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      id_ready       = ($urandom_range(2, 0) != 0);
      r = $urandom_range(9, 0);
      if (r < 6) dnpc = model_pc + 64'd4;
      else if (r < 8) dnpc = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_0FFC)};
      else if (r == 8) dnpc = model_pc + 64'd2;
      else dnpc = 64'hFFFF_FFFF_FFFF_FFFC;

      checks++;
      if (id_valid && imem_req_valid) begin
        errors++;
        $display("FAIL rnd_exclusive cyc %0d: id_valid=%b req_valid=%b required not both", cyc, id_valid, imem_req_valid);
      end
      if (imem_req_valid && imem_req_ready) begin
        checks++;
        if (model_misa || imem_addr !== {model_pc[63:3], 3'b000}) begin
          errors++;
          $display("FAIL rnd_req cyc %0d: addr=%h required %h misa=%b", cyc, imem_addr, {model_pc[63:3], 3'b000}, model_misa);
        end
      end
      if (id_valid && id_ready) begin
        w = mem_word({model_pc[63:3], 3'b000});
        if (model_misa || mem_fault({model_pc[63:3], 3'b000})) begin
          exp_instr = NOP;
          exp_err   = 1;
        end else begin
          exp_instr = model_pc[2] ? w[63:32] : w[31:0];
          exp_err   = 0;
        end
        checks++;
        if (instr_o !== exp_instr || fetch_err !== exp_err || pc_o !== model_pc) begin
          errors++;
          $display("FAIL rnd_deliver cyc %0d: instr=%h err=%b pc=%h required %h %b %h", cyc, instr_o, fetch_err, pc_o, exp_instr, exp_err, model_pc);
        end
        model_pc   = dnpc;
        model_misa = (dnpc[1:0] != 2'b00);
        n_hs++;
      end
      tick();
    end
    id_ready = 1'b0;
    checks++;
    if (n_hs < 100) begin
      errors++;
      $display("FAIL rnd_progress: handshakes=%0d required >= 100", n_hs);
    end
  endtask

  initial begin
    test_reset();
    test_upper_word();
    test_stall();
    test_fault();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, required finish before 1ms");
    $fatal(1, "timeout");
  end

endmodule
